spi_tx_feeder: RTL and testbench
================================

SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO depth in bytes (power of two, 2..256).
REQ-002 SHALL have parameter GAP_CYCLES, default 8, meaning idle clk cycles enforced between consecutive bytes (0..255).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_data  input  8  byte to queue.
REQ-006 SHALL have port wr_en  input  1  write strobe; one byte per cycle when high.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds zero bytes.
REQ-009 SHALL have port count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 SHALL have port tx_data  output  8  byte presented to the SPI leader transmitter datain.
REQ-011 SHALL have port tx_send  output  1  start request to the transmitter send input.
REQ-012 SHALL have port tx_busy  input  1  transmitter busy flag.

Function
REQ-013 SHALL accept a write iff wr_en=1 and full=0 at that edge; a write while full SHALL be dropped with FIFO contents unchanged.
REQ-014 SHALL update count by +1 on accepted write, -1 on pop, and leave it unchanged on simultaneous accepted write and pop.
REQ-015 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated bytes.
REQ-016 SHALL implement states IDLE, LOAD, REQ, XFER, GAP.
REQ-017 IDLE: when empty=0 and tx_busy=0 -> LOAD.
REQ-018 LOAD: pop head byte into tx_data register, count decrements this edge -> REQ.
REQ-019 REQ: tx_send=1; stay until tx_busy=1 is sampled, then -> XFER.
REQ-020 XFER: tx_send=0; stay while tx_busy=1; on tx_busy=0 -> GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
REQ-021 GAP: count GAP_CYCLES cycles, then -> IDLE.
REQ-022 tx_data SHALL remain stable from LOAD exit until XFER exit.
REQ-023 First tx_send assertion SHALL occur 2 cycles after the edge accepting a write into an empty FIFO in IDLE.
REQ-024 A pop SHALL occur only in LOAD, never when empty=1.
REQ-025 A write arriving during any state SHALL be queued and not disturb the byte in flight.

Reset
REQ-026 On reset=1 at a clock edge SHALL set state=IDLE, pointers=0, count=0, empty=1, full=0, tx_send=0, tx_data=8'h00, gap counter=0.
REQ-027 Reset mid-transfer SHALL discard queued bytes and drop tx_send the following cycle regardless of tx_busy.
REQ-028 wr_en during reset SHALL be ignored.

Configuration
REQ-029 SHALL support macro SPI_TX_FEEDER_OVERFLOW_FLAG_EN.
REQ-030 When defined: output overflow (1 bit) SHALL set on any write dropped due to full, stay set until reset, reset value 0.
REQ-031 When undefined: no overflow port, no associated logic; all other behaviour identical.

Structure
REQ-032 State encoding constants (IDLE, LOAD, REQ, XFER, GAP) SHALL reside in shared package spi_pkg, alongside the byte width constant (8).
REQ-033 FIFO storage and pointers SHALL be a sub-module spi_byte_fifo; the state machine SHALL reside in spi_tx_feeder.

Verification
REQ-034 Reset, write 8'h95 -> tx_data=8'h95, tx_send=1 two cycles later; drops one cycle after tx_busy rises.
REQ-035 Write 8'h95 then 8'h54 back-to-back with model transmitter busy 80 cycles -> second tx_send rises exactly GAP_CYCLES+2 cycles after tx_busy falls, tx_data=8'h54.
REQ-036 Write 17 bytes 8'h00..8'h10 with tx_busy held 1 -> full=1 at count=16, byte 8'h10 dropped, overflow=1 if macro defined; drain yields 8'h00..8'h0F in order.
REQ-037 Simultaneous wr_en and LOAD pop at count=16 -> write dropped (full sampled), count=15.
REQ-038 Assert reset while in XFER with 3 bytes queued -> count=0, empty=1, tx_send=0; tx_busy falling afterwards generates no tx_send.
REQ-039 tx_busy held 0 in REQ for 50 cycles -> tx_send stays 1, tx_data unchanged, count unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI transmit feeder slice.
//   BYTE_W         : width of one queued/transmitted byte
//   GAP_CNT_W      : width of the inter-byte gap counter (GAP_CYCLES <= 255)
//   feeder_state_e : state encoding of the feeder sequencer
//   gap_last()     : terminal value of the gap counter for a given gap length
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int BYTE_W    = 8;
  localparam int GAP_CNT_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    XFER = 3'd3,
    GAP  = 3'd4
  } feeder_state_e;

  // The gap counter starts at zero on GAP entry, so the last GAP cycle is the
  // one where the counter equals gap_cycles-1. A zero-length gap never enters
  // GAP at all, so its terminal value is irrelevant and pinned to zero.
  function automatic logic [GAP_CNT_W-1:0] gap_last(input int gap_cycles);
    logic [GAP_CNT_W-1:0] last;
    last = '0;
    if (gap_cycles > 0) begin
      last = GAP_CNT_W'(gap_cycles - 1);
    end
    return last;
  endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// -----------------------------------------------------------------------------
// spi_byte_fifo
// Synchronous byte FIFO with first-word-fall-through read data.
// Parameters:
//   DEPTH   : number of byte entries, power of two in 2..256
// Ports:
//   clk     : system clock, all state on the rising edge
//   reset   : synchronous active-high reset (pointers and occupancy cleared)
//   wr_en   : write strobe, accepted only when not full
//   wr_data : byte to store
//   rd_en   : pop strobe, honoured only when not empty
//   rd_data : byte at the head of the queue (valid while empty=0)
//   full    : DEPTH bytes stored
//   empty   : no bytes stored
//   count   : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [BYTE_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              push;
  logic              pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A write while full and a pop while empty are both silently ignored, so
  // the storage and pointers can never be corrupted by a misbehaving caller.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  // Next-state for storage, pointers and occupancy. DEPTH is a power of two,
  // so the pointers wrap modulo DEPTH simply by overflowing their width.
  // A simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: a cleared occupancy makes stale entries
  // unreachable until they are overwritten by fresh writes.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers; reset wins over any write or pop in the
  // same cycle, which is what discards queued bytes and ignores wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// -----------------------------------------------------------------------------
// spi_tx_feeder
// Queues bytes and hands them one at a time to an SPI leader transmitter,
// using its send/busy handshake and enforcing an idle gap between bytes.
// Parameters:
//   DEPTH      : FIFO depth in bytes, power of two in 2..256
//   GAP_CYCLES : idle clk cycles held in GAP after each transfer (0..255)
// Ports:
//   clk      : system clock, all logic on the rising edge
//   reset    : synchronous active-high reset
//   wr_data  : byte to queue
//   wr_en    : write strobe, one byte per cycle, dropped while full
//   full     : FIFO holds DEPTH bytes
//   empty    : FIFO holds zero bytes
//   count    : FIFO occupancy
//   tx_data  : byte presented to the transmitter datain
//   tx_send  : start request to the transmitter
//   overflow : sticky "write dropped while full" flag (optional, see below)
//   tx_busy  : transmitter busy flag
// Build option:
//   SPI_TX_FEEDER_OVERFLOW_FLAG_EN : when defined, adds the overflow output
//   and its sticky flag; when undefined neither exists.
// -----------------------------------------------------------------------------
module spi_tx_feeder
  import spi_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_send,
`ifdef SPI_TX_FEEDER_OVERFLOW_FLAG_EN
  output logic                     overflow,
`endif
  input  logic                     tx_busy
);

  localparam logic [GAP_CNT_W-1:0] GAP_LAST = gap_last(GAP_CYCLES);

  feeder_state_e          state_q,   state_d;
  logic [BYTE_W-1:0]      tx_data_q, tx_data_d;
  logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   fifo_pop;
  logic [BYTE_W-1:0]      fifo_head;

  spi_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sequencer next-state and outputs.
  // The FIFO is only ever popped in LOAD, and LOAD is only entered from IDLE
  // with a non-empty FIFO; nothing else pops, so the head byte is guaranteed
  // valid when it is captured. tx_data is only written in LOAD, which keeps
  // the byte stable for the whole REQ/XFER handshake even while new writes
  // keep arriving behind it.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    gap_cnt_d = gap_cnt_q;
    fifo_pop  = 1'b0;
    tx_send   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        fifo_pop  = 1'b1;
        tx_data_d = fifo_head;
        state_d   = REQ;
      end

      // Hold the request until the transmitter shows it has started; a
      // transmitter that never goes busy simply keeps us here.
      REQ: begin
        tx_send = 1'b1;
        if (tx_busy) begin
          state_d = XFER;
        end
      end

      XFER: begin
        if (!tx_busy) begin
          gap_cnt_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end

      // The counter starts at zero on entry, so GAP lasts exactly
      // GAP_CYCLES cycles before returning to IDLE.
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers. Reset returns to IDLE, which drops tx_send on the
  // next cycle regardless of what the transmitter is doing; a transfer that
  // was in flight is abandoned and its trailing busy is ignored because IDLE
  // only reacts to a non-empty FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign tx_data = tx_data_q;

`ifdef SPI_TX_FEEDER_OVERFLOW_FLAG_EN
  logic overflow_q, overflow_d;

  // Sticky record of any write that arrived while the FIFO was full; only
  // reset clears it.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_spi_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_spi_tx_feeder
// Self-checking bench for spi_tx_feeder. Bytes expected on the transmitter
// side are queued when written and compared when the model transmitter
// accepts a send request. Inputs are driven and outputs sampled on the
// falling clock edge. Edge timestamps use cycleCount, the index of the most
// recent rising edge.
// -----------------------------------------------------------------------------
module tb_spi_tx_feeder;

  localparam int DEPTH      = 16;
  localparam int GAP_CYCLES = 8;
  localparam int CNT_W      = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [7:0]       tx_data;
  logic             tx_send;
  logic             busyDrv;
`ifdef SPI_TX_FEEDER_OVERFLOW_FLAG_EN
  logic             overflow;
`endif

  int         compareCount  = 0;
  int         mismatchCount = 0;
  int         cycleCount    = 0;
  int         sendCount     = 0;
  int         lastSendEdge  = 0;
  int         lastWriteEdge = 0;
  int         fallEdge      = 0;
  int         busyLeft      = 0;
  int         busyLen       = 10;
  int         sendsBefore   = 0;
  bit         modelEn       = 1'b0;
  logic [7:0] expQ [$];

  spi_tx_feeder #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
`ifdef SPI_TX_FEEDER_OVERFLOW_FLAG_EN
    .overflow (overflow),
`endif
    .tx_busy  (busyDrv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to the next falling edge, then let the model transmitter react
  // to what the DUT shows there. The model accepts a send when idle, holds
  // busy for busyLen cycles, and compares the byte against the scoreboard.
  task automatic stepCycle();
    logic [7:0] expByte;
    @(negedge clk);
    if (modelEn) begin
      if (busyDrv) begin
        busyLeft--;
        if (busyLeft <= 0) begin
          busyDrv  = 1'b0;
          fallEdge = cycleCount + 1;
        end
      end else if (tx_send) begin
        sendCount++;
        lastSendEdge = cycleCount;
        checkOutput("scoreboardNonEmpty", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          expByte = expQ.pop_front();
          checkOutput("txDataAtSend", 32'(tx_data), 32'(expByte));
        end
        busyDrv  = 1'b1;
        busyLeft = busyLen;
      end
    end
  endtask

  // Drive one write for one clock; the byte is expected on the transmitter
  // side only if the bench knows the FIFO has room.
  task automatic applyStimulus(input logic [7:0] data, input bit expectAccept);
    wr_en         = 1'b1;
    wr_data       = data;
    lastWriteEdge = cycleCount + 1;
    if (expectAccept) expQ.push_back(data);
    stepCycle();
    wr_en = 1'b0;
  endtask

  task automatic waitSends(input string tag, input int target, input int budget);
    int left;
    left = budget;
    while (sendCount < target && left > 0) begin
      stepCycle();
      left--;
    end
    checkOutput(tag, 32'(sendCount), 32'(target));
  endtask

  task automatic waitBusyFall(input string tag, input int budget);
    int left;
    left = budget;
    while (busyDrv && left > 0) begin
      stepCycle();
      left--;
    end
    checkOutput(tag, 32'(busyDrv), 32'd0);
  endtask

  task automatic waitIdle(input string tag);
    waitBusyFall(tag, 500);
    repeat (GAP_CYCLES + 4) stepCycle();
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hA5;
    busyDrv = 1'b0;

    // Reset with a write strobe held: the write must be ignored.
    repeat (3) stepCycle();
    reset = 1'b0;
    wr_en = 1'b0;
    checkOutput("resetCount",   32'(count),   32'd0);
    checkOutput("resetEmpty",   32'(empty),   32'd1);
    checkOutput("resetFull",    32'(full),    32'd0);
    checkOutput("resetTxSend",  32'(tx_send), 32'd0);
    checkOutput("resetTxData",  32'(tx_data), 32'h00);
`ifdef SPI_TX_FEEDER_OVERFLOW_FLAG_EN
    checkOutput("resetOverflow", 32'(overflow), 32'd0);
`endif

    // Single byte: send two edges after the accepting edge, drop one
    // cycle after the transmitter goes busy.
    $display("[TB] single byte latency");
    modelEn = 1'b1;
    busyLen = 10;
    applyStimulus(8'h95, 1'b1);
    waitSends("firstSendSeen", sendCount + 1, 20);
    checkOutput("firstSendLatency", 32'(lastSendEdge - lastWriteEdge), 32'd2);
    checkOutput("firstTxData", 32'(tx_data), 32'h95);
    stepCycle();
    checkOutput("sendDropAfterBusy", 32'(tx_send), 32'd0);
    checkOutput("txDataDuringXfer", 32'(tx_data), 32'h95);
    waitIdle("idleAfterFirst");

    // Back-to-back pair with a long transfer: gap timing and hold of tx_data.
    $display("[TB] back-to-back pair with gap");
    busyLen = 80;
    applyStimulus(8'h95, 1'b1);
    applyStimulus(8'h54, 1'b1);
    waitSends("pairFirstSend", sendCount + 1, 20);
    checkOutput("pairCountQueued", 32'(count), 32'd1);
    waitBusyFall("pairBusyFall", 200);
    checkOutput("pairTxDataHeld", 32'(tx_data), 32'h95);
    waitSends("pairSecondSend", sendCount + 1, GAP_CYCLES + 20);
    checkOutput("pairGapTiming", 32'(lastSendEdge - fallEdge), 32'(GAP_CYCLES + 2));
    checkOutput("pairSecondData", 32'(tx_data), 32'h54);
    waitIdle("idleAfterPair");
    checkOutput("pairEmptyAfter", 32'(empty), 32'd1);

    // Fill past capacity with the transmitter held busy, then collide a
    // write with the first pop while still full.
    $display("[TB] fill, overflow and drain");
    modelEn = 1'b0;
    busyDrv = 1'b1;
    stepCycle();
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b1);
    checkOutput("fillFull",  32'(full),  32'd1);
    checkOutput("fillCount", 32'(count), 32'd16);
    applyStimulus(8'h10, 1'b0);
    checkOutput("dropCount", 32'(count), 32'd16);
`ifdef SPI_TX_FEEDER_OVERFLOW_FLAG_EN
    checkOutput("overflowSet", 32'(overflow), 32'd1);
`endif
    busyDrv = 1'b0;
    stepCycle();
    applyStimulus(8'hAA, 1'b0);
    checkOutput("collideCount", 32'(count), 32'd15);
    checkOutput("collideFull",  32'(full),  32'd0);
    checkOutput("collideSend",  32'(tx_send), 32'd1);
    modelEn = 1'b1;
    busyLen = 3;
    waitSends("drainAll", sendCount + 16, 16 * (GAP_CYCLES + 12) + 50);
    waitIdle("idleAfterDrain");
    checkOutput("drainCount", 32'(count), 32'd0);
`ifdef SPI_TX_FEEDER_OVERFLOW_FLAG_EN
    checkOutput("overflowSticky", 32'(overflow), 32'd1);
`endif

    // Transmitter never goes busy: request must be held steadily.
    $display("[TB] stalled request, then reset mid-transfer");
    modelEn = 1'b0;
    busyDrv = 1'b0;
    applyStimulus(8'h3C, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("stallReqRaised", 32'(tx_send), 32'd1);
    applyStimulus(8'h77, 1'b1);
    applyStimulus(8'h88, 1'b1);
    applyStimulus(8'h99, 1'b1);
    repeat (46) stepCycle();
    checkOutput("stallSendHeld", 32'(tx_send), 32'd1);
    checkOutput("stallTxData",   32'(tx_data), 32'h3C);
    checkOutput("stallCount",    32'(count),   32'd3);

    // Release into a long transfer, then reset while busy with 3 queued.
    modelEn = 1'b1;
    busyLen = 40;
    stepCycle();
    repeat (3) stepCycle();
    checkOutput("xferCount", 32'(count), 32'd3);
    reset   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    stepCycle();
    reset = 1'b0;
    wr_en = 1'b0;
    expQ.delete();
    checkOutput("midResetCount",  32'(count),   32'd0);
    checkOutput("midResetEmpty",  32'(empty),   32'd1);
    checkOutput("midResetTxSend", 32'(tx_send), 32'd0);
    checkOutput("midResetTxData", 32'(tx_data), 32'h00);
`ifdef SPI_TX_FEEDER_OVERFLOW_FLAG_EN
    checkOutput("midResetOverflow", 32'(overflow), 32'd0);
`endif
    sendsBefore = sendCount;
    waitBusyFall("midResetBusyFall", 100);
    repeat (GAP_CYCLES + 10) stepCycle();
    checkOutput("noSendAfterReset", 32'(sendCount), 32'(sendsBefore));
    checkOutput("idleTxSendLow",    32'(tx_send),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
